// File: rtl/dcache_line_mover.sv
// Moves one 8-word cache line between the data cache and the AXI bridge:
// a victim writeback burst, a refill read burst, or writeback followed by refill.
module dcache_line_mover #(
  parameter int AXI_WORDS = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         fill_req_i,
  input  logic         evict_req_i,
  input  logic [31:0]  line_addr_i,
  input  logic [31:0]  evict_addr_i,
  input  logic [255:0] evict_data_i,
  output logic         req_accept_o,
  output logic         done_o,
  output logic         error_o,
  output logic [255:0] fill_data_o,
  output logic [3:0]   mem_wr_o,
  output logic         mem_rd_o,
  output logic [7:0]   mem_len_o,
  output logic [31:0]  mem_addr_o,
  output logic [31:0]  mem_write_data_o,
  input  logic         mem_accept_i,
  input  logic         mem_ack_i,
  input  logic         mem_error_i,
  input  logic [31:0]  mem_read_data_i
);

  localparam logic [2:0] LAST_BEAT = 3'(AXI_WORDS - 1);
  localparam logic [7:0] BURST_LEN = 8'(AXI_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_BEAT,
    WB_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_e;

  state_e            state_q;
  logic [2:0]        beat_q;
  logic [2:0]        beat_d;
  logic [26:0]       evict_addr_q;
  logic [26:0]       line_addr_q;
  logic [7:0][31:0]  evict_data_q;
  logic [7:0][31:0]  fill_data_q;
  logic              fill_pend_q;
  logic              error_q;
  logic              done_q;
  logic [3:0]        mem_wr_q;
  logic              mem_rd_q;
  logic [7:0]        mem_len_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;

  // Byte offset within the line is meaningless for whole-line transfers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{line_addr_i[4:0], evict_addr_i[4:0]};

  assign beat_d = beat_q + 3'd1;

  // Accept is gated by reset so a request held across reset is never reported taken.
  assign req_accept_o = rst_ni && (state_q == IDLE) && (fill_req_i || evict_req_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      evict_addr_q <= '0;
      line_addr_q  <= '0;
      evict_data_q <= '0;
      fill_data_q  <= '0;
      fill_pend_q  <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      mem_wr_q     <= '0;
      mem_rd_q     <= 1'b0;
      mem_len_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_req_i || evict_req_i) begin
            error_q      <= 1'b0;
            evict_addr_q <= evict_addr_i[31:5];
            line_addr_q  <= line_addr_i[31:5];
            evict_data_q <= evict_data_i;
            fill_pend_q  <= fill_req_i;
            beat_q       <= '0;
            mem_len_q    <= BURST_LEN;
            if (evict_req_i) begin
              state_q     <= WB_BEAT;
              mem_wr_q    <= 4'hF;
              mem_addr_q  <= {evict_addr_i[31:5], 5'b0};
              mem_wdata_q <= evict_data_i[31:0];
            end else begin
              state_q    <= RD_REQ;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {line_addr_i[31:5], 5'b0};
            end
          end
        end

        WB_BEAT: begin
          if (mem_accept_i) begin
            if (beat_q == LAST_BEAT) begin
              state_q     <= WB_RESP;
              beat_q      <= '0;
              mem_wr_q    <= '0;
              mem_len_q   <= '0;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
            end else begin
              beat_q      <= beat_d;
              mem_addr_q  <= {evict_addr_q, beat_d, 2'b00};
              mem_wdata_q <= evict_data_q[beat_d];
            end
          end
        end

        WB_RESP: begin
          if (mem_ack_i) begin
            error_q <= error_q | mem_error_i;
            if (fill_pend_q) begin
              state_q    <= RD_REQ;
              mem_rd_q   <= 1'b1;
              mem_len_q  <= BURST_LEN;
              mem_addr_q <= {line_addr_q, 5'b0};
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          if (mem_accept_i) begin
            state_q    <= RD_DATA;
            beat_q     <= '0;
            mem_rd_q   <= 1'b0;
            mem_len_q  <= '0;
            mem_addr_q <= '0;
          end
        end

        RD_DATA: begin
          if (mem_ack_i) begin
            fill_data_q[beat_q] <= mem_read_data_i;
            error_q             <= error_q | mem_error_i;
            beat_q              <= beat_d;
            if (beat_q == LAST_BEAT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o           = done_q;
  assign error_o          = error_q;
  assign fill_data_o      = fill_data_q;
  assign mem_wr_o         = mem_wr_q;
  assign mem_rd_o         = mem_rd_q;
  assign mem_len_o        = mem_len_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_write_data_o = mem_wdata_q;

endmodule
